product_accumulator: RTL and testbench

//  Downstream consumer of the pipelined bit-serial multiplier. Sums a run of

---
 rtl/product_accumulator_if.sv | 41 ++++
 rtl/product_accumulator.sv | 175 +++++++++++++++++
 tb/tb_product_accumulator.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// Bundles the signals between the multiplier array, the product accumulator
// and the writeback stage.
//   master : upstream/downstream side. It drives the products, cfg_len,
//            clear and out_ready, and observes ready, results and status.
//   slave  : the accumulator itself.
// Signals:
//   clear      sync abort of the partial sum and the result FIFO
//   cfg_len    products per result (0 is treated as 1)
//   prod_*     product valid/ready handshake (signed products)
//   out_*      result valid/ready handshake (show-ahead FIFO head)
//   fifo_count result FIFO occupancy
//   ovf        sticky signed-overflow flag
interface product_accumulator_if #(
    parameter int PROD_W     = 64,
    parameter int ACC_W      = 72,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             clear;
    logic [LEN_W-1:0]  cfg_len;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic              ovf;

    modport master (
        output clear, cfg_len, prod_valid, prod_data, out_ready,
        input  prod_ready, out_valid, out_data, fifo_count, ovf
    );

    modport slave (
        input  clear, cfg_len, prod_valid, prod_data, out_ready,
        output prod_ready, out_valid, out_data, fifo_count, ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums runs of signed products from the bit-serial multiplier into
// dot-product results and buffers them in a show-ahead FIFO.
// Ports:
//   clk_gate  clock (gated upstream)
//   rst_n     asynchronous active-low reset
//   bus       product_accumulator_if.slave: product handshake, result
//             handshake, cfg_len, clear, fifo_count, ovf
// The clear input acts as a synchronous abort. It has priority over accepts
// and pops.
module product_accumulator #(
    parameter int PROD_W     = 64,
    parameter int ACC_W      = 72,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_gate,
    input  logic                   rst_n,
    product_accumulator_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ACC_W-1:0]  acc_r, acc_nxt_s;
    logic [LEN_W-1:0]  cnt_r, cnt_nxt_s;
    logic [LEN_W-1:0]  len_q_r, len_nxt_s;
    logic              ovf_r;
    logic              ovf_set_s;

    logic              push_s;
    logic [ACC_W-1:0]  push_data_s;
    logic              pop_s;
    logic              acc_fire_s;
    logic              prod_ready_s;

    logic [ACC_W-1:0]  sext_s;
    logic [ACC_W-1:0]  sum_s;
    logic [LEN_W-1:0]  eff_len_s;
    logic [LEN_W-1:0]  cnt_inc_s;

    logic [ACC_W-1:0]  mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Ready is based only on the current occupancy. It does not look ahead at a pop in the same cycle.
    assign prod_ready_s   = (count_r < CNT_W'(FIFO_DEPTH));
    assign acc_fire_s     = bus.prod_valid & prod_ready_s;
    assign pop_s          = (count_r != {CNT_W{1'b0}}) & bus.out_ready;

    assign sext_s         = ACC_W'($signed(bus.prod_data));
    assign sum_s          = acc_r + sext_s;
    assign eff_len_s      = (bus.cfg_len == {LEN_W{1'b0}}) ? LEN_W'(1'b1) : bus.cfg_len;
    assign cnt_inc_s      = cnt_r + LEN_W'(1'b1);

    assign bus.prod_ready = prod_ready_s;
    assign bus.out_valid  = (count_r != {CNT_W{1'b0}});
    assign bus.out_data   = mem_r[rd_ptr_r];
    assign bus.fifo_count = count_r;
    assign bus.ovf        = ovf_r;

    // Run sequencing: start a run, accumulate, and push the finished sum into the FIFO.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        len_nxt_s   = len_q_r;
        push_s      = 1'b0;
        push_data_s = sum_s;
        ovf_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acc_fire_s) begin
                    // cfg_len is sampled only here, on the first product of a run.
                    len_nxt_s = eff_len_s;
                    if (eff_len_s == LEN_W'(1'b1)) begin
                        push_s      = 1'b1;
                        push_data_s = sext_s;
                    end else begin
                        acc_nxt_s   = sext_s;
                        cnt_nxt_s   = LEN_W'(1'b1);
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (acc_fire_s) begin
                    // Operands have the same sign but the wrapped sum has the opposite sign.
                    ovf_set_s = (acc_r[ACC_W-1] == sext_s[ACC_W-1]) &&
                                (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
                    if (cnt_inc_s == len_q_r) begin
                        push_s      = 1'b1;
                        push_data_s = sum_s;
                        acc_nxt_s   = {ACC_W{1'b0}};
                        cnt_nxt_s   = {LEN_W{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end else begin
                        acc_nxt_s = sum_s;
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registers for the FSM state, the partial sum and the run length.
    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {LEN_W{1'b0}};
            len_q_r <= LEN_W'(1'b1);
        end else if (bus.clear) begin
            state_r <= ST_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            len_q_r <= len_nxt_s;
        end
    end

    // Sticky overflow flag. It is cleared only by reset or clear.
    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (bus.clear) begin
            ovf_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Show-ahead result FIFO. Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_gate or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ACC_W{1'b0}};
            end
        end else if (bus.clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. dut_a uses a 72-bit
// accumulator and is checked every cycle against a queue-based model of
// runs and buffered results. dut_b uses ACC_W == PROD_W and covers the
// signed-overflow case.
module tb_product_accumulator;
    localparam int PROD_W = 64;
    localparam int ACC_W  = 72;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 4;

    logic clk_gate = 1'b0;
    logic rst_n;

    always #5 clk_gate = ~clk_gate;

    product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W),  .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) bus_a ();
    product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(PROD_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) bus_b ();

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk_gate (clk_gate),
        .rst_n    (rst_n),
        .bus      (bus_a)
    );

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(PROD_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk_gate (clk_gate),
        .rst_n    (rst_n),
        .bus      (bus_b)
    );

    // Reference model: the current run plus a queue of finished results.
    logic signed [ACC_W-1:0] m_q[$];
    logic signed [ACC_W-1:0] m_sum;
    bit                      m_in_run;
    int                      m_n;
    int                      m_len;
    bit                      m_ovf;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sum    = '0;
        m_in_run = 1'b0;
        m_n      = 0;
        m_len    = 1;
        m_ovf    = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge(input bit v, input logic signed [PROD_W-1:0] p, input int cfg,
                              input bit rdy, input bit clr);
        bit take;
        bit pop;
        logic signed [ACC_W:0] wide;
        if (clr) begin
            m_q.delete();
            m_sum    = '0;
            m_in_run = 1'b0;
            m_n      = 0;
            m_ovf    = 1'b0;
        end else begin
            take = v && (m_q.size() < DEPTH);
            pop  = (m_q.size() != 0) && rdy;
            if (pop) void'(m_q.pop_front());
            if (take) begin
                if (!m_in_run) begin
                    m_len = (cfg == 0) ? 1 : cfg;
                    m_sum = p;
                    m_n   = 1;
                end else begin
                    // Exact sum one bit wider; overflow if it does not fit in ACC_W.
                    wide = m_sum + p;
                    if (wide[ACC_W] != wide[ACC_W-1]) m_ovf = 1'b1;
                    m_sum = wide[ACC_W-1:0];
                    m_n++;
                end
                if (m_n == m_len) begin
                    m_q.push_back(m_sum);
                    m_in_run = 1'b0;
                    m_sum    = '0;
                end else begin
                    m_in_run = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_a();
        check_val("out_valid",  ACC_W'(bus_a.out_valid),  ACC_W'(m_q.size() != 0));
        check_val("fifo_count", ACC_W'(bus_a.fifo_count), ACC_W'(m_q.size()));
        check_val("prod_ready", ACC_W'(bus_a.prod_ready), ACC_W'(m_q.size() < DEPTH));
        check_val("ovf",        ACC_W'(bus_a.ovf),        ACC_W'(m_ovf));
        if (m_q.size() != 0) check_val("out_data", bus_a.out_data, m_q[0]);
    endtask

    // Drive one cycle on dut_a (entered and left at a negedge), then compare it with the model.
    task automatic cycle(input bit v, input logic signed [PROD_W-1:0] p, input int cfg,
                         input bit rdy, input bit clr);
        bus_a.prod_valid = v;
        bus_a.prod_data  = p;
        bus_a.cfg_len    = LEN_W'(cfg);
        bus_a.out_ready  = rdy;
        bus_a.clear      = clr;
        model_edge(v, p, cfg, rdy, clr);
        @(posedge clk_gate);
        @(negedge clk_gate);
        compare_a();
    endtask

    task automatic check_reset_outputs(input string who);
        if (who == "a") begin
            check_val("rst_a_valid", ACC_W'(bus_a.out_valid),  '0);
            check_val("rst_a_data",  bus_a.out_data,           '0);
            check_val("rst_a_count", ACC_W'(bus_a.fifo_count), '0);
            check_val("rst_a_ovf",   ACC_W'(bus_a.ovf),        '0);
            check_val("rst_a_ready", ACC_W'(bus_a.prod_ready), ACC_W'(1));
        end else begin
            check_val("rst_b_valid", ACC_W'(bus_b.out_valid),  '0);
            check_val("rst_b_data",  ACC_W'(bus_b.out_data),   '0);
            check_val("rst_b_count", ACC_W'(bus_b.fifo_count), '0);
            check_val("rst_b_ovf",   ACC_W'(bus_b.ovf),        '0);
            check_val("rst_b_ready", ACC_W'(bus_b.prod_ready), ACC_W'(1));
        end
    endtask

    logic signed [PROD_W-1:0] rnd_p;
    bit                       rnd_v;
    bit                       rnd_r;
    bit                       rnd_c;
    int                       rnd_len;

    initial begin
        rst_n = 1'b0;
        bus_a.prod_valid = 1'b0; bus_a.prod_data = '0; bus_a.cfg_len = '0;
        bus_a.out_ready  = 1'b0; bus_a.clear = 1'b0;
        bus_b.prod_valid = 1'b0; bus_b.prod_data = '0; bus_b.cfg_len = '0;
        bus_b.out_ready  = 1'b0; bus_b.clear = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("a");
        check_reset_outputs("b");
        @(negedge clk_gate);
        rst_n = 1'b1;

        // A run of 4 products gives one result, visible right after the last accept.
        cycle(1'b1, 64'sd3,  4, 1'b1, 1'b0);
        cycle(1'b1, -64'sd5, 4, 1'b1, 1'b0);
        cycle(1'b1, 64'sd7,  4, 1'b1, 1'b0);
        cycle(1'b1, 64'sd2,  4, 1'b1, 1'b0);
        check_val("t1_valid", ACC_W'(bus_a.out_valid), ACC_W'(1));
        check_val("t1_data",  bus_a.out_data, 72'sd7);
        cycle(1'b0, '0, 4, 1'b1, 1'b0);

        // A length of 0 acts as 1.
        cycle(1'b1, 64'sd9, 0, 1'b1, 1'b0);
        check_val("t2_first", bus_a.out_data, 72'sd9);
        cycle(1'b1, -64'sd9, 0, 1'b1, 1'b0);
        check_val("t2_second", bus_a.out_data, -72'sd9);
        cycle(1'b0, '0, 0, 1'b1, 1'b0);

        // Fill the FIFO. The 5th product is held off, with no look-ahead at a pop.
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(100 + i), 1, 1'b0, 1'b0);
        cycle(1'b1, 64'sd104, 1, 1'b0, 1'b0);
        check_val("t3_count_full", ACC_W'(bus_a.fifo_count), ACC_W'(4));
        check_val("t3_ready_full", ACC_W'(bus_a.prod_ready), '0);
        cycle(1'b1, 64'sd104, 1, 1'b1, 1'b0);
        check_val("t3_head1", bus_a.out_data, 72'sd101);
        check_val("t3_no_lookahead", ACC_W'(bus_a.fifo_count), ACC_W'(3));
        cycle(1'b1, 64'sd104, 1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1, 1'b1, 1'b0);

        // Clear drops a partial sum and a product offered in the same cycle.
        cycle(1'b1, 64'sd10, 3, 1'b1, 1'b0);
        cycle(1'b1, 64'sd20, 3, 1'b1, 1'b0);
        cycle(1'b1, 64'sd50, 3, 1'b1, 1'b1);
        check_val("t5_cleared", ACC_W'(bus_a.fifo_count), '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'sd1, 3, 1'b1, 1'b0);
        check_val("t5_result", bus_a.out_data, 72'sd3);
        cycle(1'b0, '0, 3, 1'b1, 1'b0);

        // Randomized traffic, including cfg_len changes mid-run and occasional clears.
        for (int i = 0; i < 400; i++) begin
            rnd_v   = ($urandom_range(0, 3) != 0);
            rnd_r   = ($urandom_range(0, 2) != 0);
            rnd_c   = ($urandom_range(0, 49) == 0);
            rnd_len = $urandom_range(0, 5);
            rnd_p   = $signed({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 1) rnd_p = rnd_p >>> 50;
            cycle(rnd_v, rnd_p, rnd_len, rnd_r, rnd_c);
        end
        cycle(1'b0, '0, 0, 1'b1, 1'b1);
        bus_a.clear = 1'b0;
        bus_a.out_ready = 1'b0;

        // Signed overflow with ACC_W == PROD_W. The flag is sticky until clear.
        bus_b.cfg_len    = 8'd2;
        bus_b.prod_valid = 1'b1;
        bus_b.prod_data  = 64'h7FFF_FFFF_FFFF_FFFF;
        @(posedge clk_gate); @(negedge clk_gate);
        bus_b.prod_data  = 64'd1;
        @(posedge clk_gate); @(negedge clk_gate);
        bus_b.prod_valid = 1'b0;
        check_val("t4_valid", ACC_W'(bus_b.out_valid), ACC_W'(1));
        check_val("t4_data",  ACC_W'(bus_b.out_data), ACC_W'(64'h8000_0000_0000_0000));
        check_val("t4_ovf",   ACC_W'(bus_b.ovf), ACC_W'(1));
        @(posedge clk_gate); @(negedge clk_gate);
        check_val("t4_ovf_sticky", ACC_W'(bus_b.ovf), ACC_W'(1));
        bus_b.clear = 1'b1;
        @(posedge clk_gate); @(negedge clk_gate);
        bus_b.clear = 1'b0;
        check_val("t4_ovf_clr",   ACC_W'(bus_b.ovf), '0);
        check_val("t4_count_clr", ACC_W'(bus_b.fifo_count), '0);

        // Asynchronous reset in the middle of a gapped run, with a result buffered.
        cycle(1'b1, 64'sd77, 1, 1'b0, 1'b0);
        cycle(1'b1, 64'sd5,  3, 1'b0, 1'b0);
        cycle(1'b0, '0,      3, 1'b0, 1'b0);
        cycle(1'b0, '0,      3, 1'b0, 1'b0);
        cycle(1'b1, 64'sd6,  3, 1'b0, 1'b0);
        check_val("t6_pre_valid", ACC_W'(bus_a.out_valid), ACC_W'(1));
        #1;
        rst_n = 1'b0;
        bus_a.prod_valid = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("a");
        check_reset_outputs("b");
        @(negedge clk_gate);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'sd1, 3, 1'b1, 1'b0);
        check_val("t6_no_stale", bus_a.out_data, 72'sd3);
        cycle(1'b0, '0, 3, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
